// File: rtl/result_writeback.sv
// result_writeback: captures one DSP result per result_ready rising edge, optional ReLU,
// buffers in a FIFO and drains it to output memory at offset + written.
module result_writeback #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] output_memory_offset,
    input  logic [15:0] output_count,
    input  logic        relu_en,
    input  logic        result_ready,
    input  logic [17:0] result_data,
    output logic        write_en,
    output logic [15:0] write_addr,
    output logic [17:0] write_data,
    input  logic        write_grant,
    output logic [15:0] written,
    output logic        overflow,
    output logic        done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          rr_q, relu_q, overflow_q, done_q;
    logic [15:0]   offset_q, count_q, written_q, written_d;
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          run, empty, full, push, pop, accept;
    logic [17:0]   push_data;

    assign run        = state_q == S_RUN;
    assign empty      = cnt_q == '0;
    assign full       = cnt_q == (AW+1)'(FIFO_DEPTH);
    // a rising edge coinciding with start is deliberately not captured
    assign push       = run && !start && result_ready && !rr_q;
    assign pop        = write_en && write_grant;
    assign accept     = push && (!full || pop);
    assign push_data  = (relu_q && result_data[17]) ? '0 : result_data;
    assign write_en   = run && !empty;
    assign write_addr = offset_q + written_q;
    assign write_data = mem_q[rptr_q];
    assign written    = written_q;
    assign overflow   = overflow_q;
    assign done       = done_q;
    assign written_d  = written_q + 16'(pop);
    assign state_d    = start ? S_RUN : (run && written_d == count_q) ? S_DONE : state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            relu_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            offset_q   <= '0;
            count_q    <= '0;
            written_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= state_d == S_DONE;
            rr_q    <= start ? 1'b0 : result_ready;
            if (start) begin
                offset_q   <= output_memory_offset;
                count_q    <= output_count;
                relu_q     <= relu_en;
                overflow_q <= 1'b0;
                written_q  <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                cnt_q      <= '0;
            end else begin
                if (accept) begin
                    mem_q[wptr_q] <= push_data;
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (pop) rptr_q <= rptr_q + 1'b1;
                if (push && full && !pop) overflow_q <= 1'b1;
                cnt_q     <= cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
                written_q <= written_d;
            end
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed vectors plus hand sequences for stall, overflow,
// restart, zero count and asynchronous reset.
module tb_result_writeback;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, relu_en = 1'b0;
    logic [15:0] offset = '0, count = '0;
    logic        result_ready = 1'b0, write_grant = 1'b0;
    logic [17:0] result_data = '0;
    logic        write_en, overflow, done;
    logic [15:0] write_addr, written;
    logic [17:0] write_data;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        logic [15:0]      a;
        logic [17:0]      d;
    } wr_t;
    wr_t log_q[$];

    typedef struct {
        logic [15:0]      off;
        logic             relu;
        logic [2:0][17:0] din;
        logic [2:0][15:0] ea;
        logic [2:0][17:0] ed;
    } vec_t;
    vec_t vecs[4];

    result_writeback #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .output_memory_offset(offset), .output_count(count), .relu_en(relu_en),
        .result_ready(result_ready), .result_data(result_data),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .write_grant(write_grant), .written(written), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (write_en && write_grant) log_q.push_back('{write_addr, write_data});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] off, input logic [15:0] cnt, input logic relu);
        start = 1'b1; offset = off; count = cnt; relu_en = relu;
        step();
        start = 1'b0; offset = 16'hDEAD; count = 16'hBEEF; relu_en = ~relu;
    endtask

    task automatic pulse(input logic [17:0] d);
        result_ready = 1'b1; result_data = d;
        step(2);
        result_ready = 1'b0; result_data = 18'h2AAAA;
        step();
    endtask

    initial begin
        vecs[0] = '{16'h0100, 1'b0, {18'h00007, 18'h3FFFF, 18'h00005},
                    {16'h0102, 16'h0101, 16'h0100}, {18'h00007, 18'h3FFFF, 18'h00005}};
        vecs[1] = '{16'h0100, 1'b1, {18'h00007, 18'h3FFFF, 18'h00005},
                    {16'h0102, 16'h0101, 16'h0100}, {18'h00007, 18'h00000, 18'h00005}};
        vecs[2] = '{16'hFFFE, 1'b0, {18'h20000, 18'h00002, 18'h00001},
                    {16'h0000, 16'hFFFF, 16'hFFFE}, {18'h20000, 18'h00002, 18'h00001}};
        vecs[3] = '{16'h1234, 1'b1, {18'h00000, 18'h20000, 18'h1FFFF},
                    {16'h1236, 16'h1235, 16'h1234}, {18'h00000, 18'h00000, 18'h1FFFF}};

        step(2);
        check("reset write_en", write_en, 0);
        check("reset write_addr", write_addr, 0);
        check("reset write_data", write_data, 0);
        check("reset written", written, 0);
        check("reset overflow", overflow, 0);
        check("reset done", done, 0);
        rst = 1'b0;
        write_grant = 1'b1;
        step();
        pulse(18'h11);
        step(2);
        check("idle pulse no write", log_q.size(), 0);

        foreach (vecs[i]) begin
            log_q.delete();
            do_start(vecs[i].off, 16'd3, vecs[i].relu);
            for (int k = 0; k < 3; k++) pulse(vecs[i].din[k]);
            step(2);
            check($sformatf("v%0d write count", i), log_q.size(), 3);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("v%0d addr%0d", i, k), log_q[k].a, vecs[i].ea[k]);
                check($sformatf("v%0d data%0d", i, k), log_q[k].d, vecs[i].ed[k]);
            end
            check($sformatf("v%0d written", i), written, 3);
            check($sformatf("v%0d done", i), done, 1);
            check($sformatf("v%0d overflow", i), overflow, 0);
        end
        log_q.delete();
        pulse(18'h22);
        step(2);
        check("done pulse no write", log_q.size(), 0);

        // exact latency for a single result with grant high
        do_start(16'h0050, 16'd1, 1'b0);
        check("lat done low after start", done, 0);
        result_ready = 1'b1; result_data = 18'h0ABC;
        step();
        check("lat write_en after push", write_en, 1);
        check("lat write_data", write_data, 18'h0ABC);
        check("lat written before pop", written, 0);
        step();
        check("lat written after pop", written, 1);
        check("lat done", done, 1);
        check("lat write_en after done", write_en, 0);
        result_ready = 1'b0;
        step();

        // stall with overflow, then drain
        log_q.delete();
        write_grant = 1'b0;
        do_start(16'h0200, 16'd8, 1'b0);
        for (int k = 0; k < 5; k++) begin
            pulse(18'(10 + k));
            check($sformatf("stall write_en %0d", k), write_en, 1);
            check($sformatf("stall addr %0d", k), write_addr, 16'h0200);
            check($sformatf("stall data %0d", k), write_data, 18'd10);
        end
        check("stall overflow", overflow, 1);
        write_grant = 1'b1;
        step(6);
        check("drain count", log_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain addr%0d", k), log_q[k].a, 16'(16'h0200 + k));
            check($sformatf("drain data%0d", k), log_q[k].d, 18'(10 + k));
        end
        check("drain written", written, 4);
        check("drain write_en", write_en, 0);
        check("drain done", done, 0);
        check("overflow sticky", overflow, 1);

        // full FIFO with simultaneous push and pop accepts the push
        log_q.delete();
        write_grant = 1'b0;
        do_start(16'h0000, 16'd5, 1'b0);
        check("restart clears overflow", overflow, 0);
        for (int k = 0; k < 4; k++) pulse(18'(20 + k));
        result_ready = 1'b1; result_data = 18'd24; write_grant = 1'b1;
        step();
        result_ready = 1'b0;
        step(6);
        check("fullpop count", log_q.size(), 5);
        check("fullpop last data", log_q[4].d, 18'd24);
        check("fullpop overflow", overflow, 0);
        check("fullpop done", done, 1);

        // zero count
        log_q.delete();
        do_start(16'h0300, 16'd0, 1'b0);
        check("zero done after start edge", done, 0);
        step();
        check("zero done", done, 1);
        pulse(18'h33);
        step(2);
        check("zero no write", log_q.size(), 0);
        check("zero written", written, 0);

        // asynchronous reset with entries queued
        log_q.delete();
        do_start(16'h0300, 16'd5, 1'b0);
        pulse(18'h44);
        write_grant = 1'b0;
        pulse(18'h45);
        pulse(18'h46);
        check("pre-reset written", written, 1);
        check("pre-reset write_en", write_en, 1);
        #2 rst = 1'b1;
        #1;
        check("async write_en", write_en, 0);
        check("async written", written, 0);
        check("async overflow", overflow, 0);
        check("async done", done, 0);
        step();
        rst = 1'b0;
        write_grant = 1'b1;
        log_q.delete();
        do_start(16'h0400, 16'd1, 1'b0);
        pulse(18'h55);
        step(2);
        check("post-reset count", log_q.size(), 1);
        check("post-reset addr", log_q[0].a, 16'h0400);
        check("post-reset data", log_q[0].d, 18'h55);
        check("post-reset done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream consumer of the accelerator's DSP round output. Detects each new `result_ready` assertion, captures the 18-bit result, optionally applies ReLU, and buffers it in a small FIFO. Drains the FIFO into output memory at `output_memory_offset + index`. Raises `done` once the programmed number of outputs has been written.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: result buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle pulse; latches config, clears counters and flags, enters RUN.
- `output_memory_offset`  in  16  base address of output region; latched on `start`.
- `output_count`  in  16  number of results to write; latched on `start`.
- `relu_en`  in  1  clamp negative results to 0; latched on `start`.
- `result_ready`  in  1  round-done level from the allocators; may stay high for several cycles per result.
- `result_data`  in  18  signed two's-complement DSP result, valid while `result_ready` is high.
- `write_en`  out  1  write request to output memory.
- `write_addr`  out  16  write address.
- `write_data`  out  18  write data.
- `write_grant`  in  1  memory accepts the write this cycle when high together with `write_en`.
- `written`  out  16  count of completed writes.
- `overflow`  out  1  sticky; a result was dropped because the FIFO was full.
- `done`  out  1  all `output_count` results written.

## Operation
- **States**
  - IDLE (reset state).
  - RUN: entered on `start` from any state.
  - DONE: entered when `written == output_count` in RUN, including immediately after `start` if `output_count == 0`.
  - A `start` in DONE or RUN restarts the block.
- **Capture**
  - Register `rr_q` holds the previous `result_ready`.
  - Push occurs when `result_ready && !rr_q` and state is RUN, so there is exactly one push per assertion.
  - Rising edges in IDLE or DONE are ignored.
- **ReLU**: applied at push. If `relu_en` and `result_data[17]` are both set, store 0; otherwise store `result_data` unchanged.
- **FIFO**
  - Circular buffer with read/write pointers and an occupancy count of width log2(`FIFO_DEPTH`)+1.
  - Full with push and no pop: the sample is dropped and `overflow` is set; it stays set until `start` or `rst`.
  - Full with push and a simultaneous pop: the push is accepted.
  - No write-through bypass; an empty FIFO can never produce `write_en`.
- **Drain**
  - `write_en` = (state RUN) && FIFO not empty.
  - `write_data` = FIFO head.
  - `write_addr` = `output_memory_offset + written`, truncated to 16 bits; wrap-around is allowed and not flagged.
  - A pop happens when `write_en && write_grant`; on that cycle `written` increments.
- **Sequencing**
  - After the last write, the state goes to DONE.
  - Any remaining FIFO entries are discarded on the next `start`.
- **Start vs push**: `start` clears the FIFO and `rr_q`. A rising edge in the same cycle as `start` is not captured.

## Timing
- **Reset values**: state IDLE, `write_en`=0, `write_addr`=0, `write_data`=0, `written`=0, `overflow`=0, `done`=0, `rr_q`=0, FIFO empty.
- **Pin behaviour**:
  - `write_en`, `write_addr` and `write_data` are combinational from registered state.
  - `done`, `written` and `overflow` are registers.
- **Latency**:
  - Rising edge sampled at clock edge E → entry stored at E.
  - `write_en` is high in the cycle following E.
  - With `write_grant` tied high: pop at edge E+1, and `written` updates after E+1.
  - `done` rises one edge after the final grant, i.e. the edge where `written` reaches the count; it is visible the cycle after that.
- **Handshake**:
  - `write_addr` and `write_data` are held stable while `write_en` is high and `write_grant` is low.
  - Sustained throughput is one write per cycle.
- **Mid-operation reset**: `rst` immediately clears all state asynchronously; `write_en` drops in the same cycle.

## Test plan
- Reset mid-RUN with 2 entries queued → `write_en`, `written`, `overflow` and `done` go to 0 at once. After `start`, the next result is written to the offset base.
- `start` with offset=0x0100, count=3, `relu_en`=0, `write_grant`=1; three `result_ready` pulses, each held 2 cycles, data 5, 0x3FFFF, 7 → writes (0x0100,5), (0x0101,0x3FFFF), (0x0102,7); `written`=3; `done`=1; no duplicate writes.
- Same stimulus with `relu_en`=1 → second write data is 0; the others are unchanged.
- `write_grant`=0 while 5 pulses arrive, `FIFO_DEPTH`=4 → `overflow`=1. Releasing the grant yields exactly 4 writes of the first 4 values, with addr/data held stable while stalled.
- Offset=0xFFFE, count=3 → addresses 0xFFFE, 0xFFFF, 0x0000.
- count=0 → `done`=1 one edge after `start`, with no writes. Pulses in IDLE or DONE produce no writes.
